// File: rtl/mem_resp.sv
// MERA-400 memory-module responder: decodes bus read/write requests to a local
// word array and answers OK / EN / PE on a fully interlocked 4-phase handshake.
module mem_resp #(
  parameter logic [3:0]  NB            = 4'd0,
  parameter int unsigned ADDR_BITS     = 12,
  parameter logic [3:0]  ACCESS_TICKS  = 4'd4,
  parameter logic [15:0] PROTECT_BELOW = 16'd0
) (
  input  logic        __clk,
  input  logic        __rst,
  input  logic        rw_,
  input  logic        rr_,
  input  logic        rmcl_,
  input  logic [0:3]  rnb_,
  input  logic [0:15] rad_,
  input  logic [0:15] rdt_,
  input  logic        par_inj,
  output logic        dok_,
  output logic        den_,
  output logic        dpe_,
  output logic [0:15] ddt_
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, REL} state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0] r_rw_s;
  logic [1:0] r_rr_s;
  logic [1:0] r_mcl_s;

  logic [ADDR_BITS-1:0] r_addr;
  logic [15:0]          r_data;
  logic                 r_wr;
  logic                 r_prot;
  logic [3:0]           r_cnt;
  logic                 r_inj;
  logic [16:0]          r_rd;
  logic [16:0]          r_mem [2**ADDR_BITS];

  logic        w_rw_lo;
  logic        w_rr_lo;
  logic        w_mcl_lo;
  logic [15:0] w_addr;
  logic [15:0] w_data;
  logic [3:0]  w_nb;
  logic        w_in_range;
  logic        w_prot;
  logic        w_match;
  logic        w_strb_lo;
  logic        w_accept;
  logic        w_enter_resp;
  logic        w_do_write;
  logic        w_pe;

  always_ff @(posedge __clk or posedge __rst) begin
    if (__rst) begin
      r_rw_s  <= '1;
      r_rr_s  <= '1;
      r_mcl_s <= '1;
    end else begin
      r_rw_s  <= {r_rw_s[0], rw_};
      r_rr_s  <= {r_rr_s[0], rr_};
      r_mcl_s <= {r_mcl_s[0], rmcl_};
    end
  end

  assign w_rw_lo  = ~r_rw_s[1];
  assign w_rr_lo  = ~r_rr_s[1];
  assign w_mcl_lo = ~r_mcl_s[1];

  assign w_addr     = ~rad_;
  assign w_data     = ~rdt_;
  assign w_nb       = ~rnb_;
  assign w_in_range = ((w_addr >> ADDR_BITS) == 16'd0);

  // A zero threshold removes the comparator entirely rather than comparing against 0.
  if (PROTECT_BELOW == 16'd0) begin : g_noprot
    assign w_prot = 1'b0;
  end else begin : g_prot
    assign w_prot = (w_addr < PROTECT_BELOW);
  end

  assign w_match   = (w_rw_lo ^ w_rr_lo) && (w_nb == NB) && w_in_range;
  assign w_strb_lo = r_wr ? w_rw_lo : w_rr_lo;

  always_ff @(posedge __clk or posedge __rst) begin
    if (__rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_mcl_lo) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_match) w_next = WAIT;
        WAIT:    if (!w_strb_lo) w_next = IDLE;
                 else if (r_cnt <= 4'd1) w_next = RESP;
        RESP:    if (!w_strb_lo) w_next = REL;
        REL:     w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  assign w_accept     = (r_state == IDLE) && (w_next == WAIT);
  assign w_enter_resp = (r_state == WAIT) && (w_next == RESP);
  assign w_do_write   = w_enter_resp && r_wr && !r_prot;

  always_ff @(posedge __clk or posedge __rst) begin
    if (__rst) begin
      r_addr <= '0;
      r_data <= '0;
      r_wr   <= 1'b0;
      r_prot <= 1'b0;
      r_cnt  <= '0;
      r_inj  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr <= w_addr[ADDR_BITS-1:0];
        r_data <= w_data;
        r_wr   <= w_rw_lo;
        r_prot <= w_prot;
        r_cnt  <= ACCESS_TICKS;
      end else if (r_state == WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // A pulse arriving while a write consumes the latch re-arms it for the next write.
      r_inj <= (r_inj & ~w_do_write) | par_inj;
    end
  end

  // Word array is never reset; bit 16 holds odd parity.
  always_ff @(posedge __clk) begin
    if (w_do_write)
      r_mem[r_addr] <= {(~^r_data) ^ r_inj, r_data};
    if (w_enter_resp && !r_wr)
      r_rd <= r_mem[r_addr];
  end

  assign w_pe = r_rd[16] != (~^r_rd[15:0]);

  always_comb begin
    dok_ = 1'b1;
    den_ = 1'b1;
    dpe_ = 1'b1;
    ddt_ = '1;
    if (r_state == RESP) begin
      if (r_wr) begin
        if (r_prot) den_ = 1'b0;
        else        dok_ = 1'b0;
      end else begin
        ddt_ = ~r_rd[15:0];
        if (w_pe) dpe_ = 1'b0;
        else      dok_ = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_resp.sv
// Scoreboard bench for mem_resp: drivers queue expected responses, a negedge
// monitor compares each response as it appears and times assert/release latency.
module tb_mem_resp;

  logic        __clk = 1'b0;
  logic        __rst = 1'b1;
  logic        rw_ = 1'b1;
  logic        rr_ = 1'b1;
  logic        rmcl_ = 1'b1;
  logic [0:3]  rnb_ = '1;
  logic [0:15] rad_ = '1;
  logic [0:15] rdt_ = '1;
  logic        par_inj = 1'b0;
  logic        dok_;
  logic        den_;
  logic        dpe_;
  logic [0:15] ddt_;

  mem_resp #(
    .NB(4'd0),
    .ADDR_BITS(12),
    .ACCESS_TICKS(4'd4),
    .PROTECT_BELOW(16'h0100)
  ) dut (
    .__clk(__clk), .__rst(__rst), .rw_(rw_), .rr_(rr_), .rmcl_(rmcl_),
    .rnb_(rnb_), .rad_(rad_), .rdt_(rdt_), .par_inj(par_inj),
    .dok_(dok_), .den_(den_), .dpe_(dpe_), .ddt_(ddt_)
  );

  always #5 __clk = ~__clk;

  int unsigned cyc = 0;
  always @(posedge __clk) cyc <= cyc + 1;

  typedef struct {
    logic [18:0] resp;
    int unsigned t0;
  } exp_t;

  localparam logic [18:0] W_OK = {3'b011, 16'hFFFF};
  localparam logic [18:0] W_EN = {3'b101, 16'hFFFF};
  localparam int unsigned RESP_LAT = 7;
  localparam int unsigned REL_LAT  = 3;

  function automatic logic [18:0] r_ok(input logic [15:0] d);
    return {3'b011, ~d};
  endfunction

  function automatic logic [18:0] r_pe(input logic [15:0] d);
    return {3'b110, ~d};
  endfunction

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          seen = 0;
  int          unexpected = 0;
  int unsigned rel_t0 = 0;
  bit          rel_chk = 1'b0;
  bit          prev_act = 1'b0;

  always @(negedge __clk) begin
    exp_t e;
    logic act;
    act = !(dok_ && den_ && dpe_);
    if (act && !prev_act) begin
      seen++;
      if (q.size() == 0) begin
        unexpected++;
      end else begin
        e = q.pop_front();
        tests++;
        if ({dok_, den_, dpe_, ddt_} !== e.resp) begin
          fails++;
          $display("FAIL resp: got ok/en/pe=%b%b%b ddt=%h, want %b ddt=%h",
                   dok_, den_, dpe_, ddt_, e.resp[18:16], e.resp[15:0]);
        end
        tests++;
        if (cyc - e.t0 != RESP_LAT) begin
          fails++;
          $display("FAIL resp_latency: got %0d cycles, want %0d", cyc - e.t0, RESP_LAT);
        end
      end
    end
    if (!act && prev_act && rel_chk) begin
      tests++;
      if (cyc - rel_t0 != REL_LAT) begin
        fails++;
        $display("FAIL release_latency: got %0d cycles, want %0d", cyc - rel_t0, REL_LAT);
      end
      rel_chk = 1'b0;
    end
    prev_act = act;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge __clk);
  endtask

  task automatic start(input bit wr, input logic [15:0] addr, input logic [15:0] data,
                       input logic [18:0] exp_resp);
    exp_t e;
    int s;
    int k;
    @(negedge __clk);
    rnb_ = ~4'd0;
    rad_ = ~addr;
    rdt_ = ~data;
    s = seen;
    e.resp = exp_resp;
    e.t0 = cyc;
    q.push_back(e);
    if (wr) rw_ = 1'b0;
    else    rr_ = 1'b0;
    k = 0;
    while (seen == s && k < 60) begin
      @(posedge __clk);
      k++;
    end
    tests++;
    if (seen == s) begin
      fails++;
      $display("FAIL resp_timeout: addr=%h got no response, want one within 60 cycles", addr);
      q.delete();
    end
  endtask

  task automatic finish_xfer();
    int k;
    @(negedge __clk);
    rel_t0 = cyc;
    rel_chk = 1'b1;
    rw_ = 1'b1;
    rr_ = 1'b1;
    k = 0;
    while (rel_chk && k < 60) begin
      @(posedge __clk);
      k++;
    end
    tests++;
    if (rel_chk) begin
      fails++;
      $display("FAIL release_timeout: outputs still active, want release within 60 cycles");
      rel_chk = 1'b0;
    end
    idle(2);
  endtask

  task automatic xfer(input bit wr, input logic [15:0] addr, input logic [15:0] data,
                      input logic [18:0] exp_resp);
    start(wr, addr, data, exp_resp);
    finish_xfer();
  endtask

  // Drive a request that must draw no response; strobes drop after 'hold' cycles.
  task automatic silent(input string name, input bit w, input bit r, input logic [3:0] nb,
                        input logic [15:0] addr, input logic [15:0] data,
                        input int hold, input int total);
    int s;
    int bad;
    @(negedge __clk);
    rnb_ = ~nb;
    rad_ = ~addr;
    rdt_ = ~data;
    s = seen;
    bad = 0;
    rw_ = ~w;
    rr_ = ~r;
    for (int i = 0; i < total; i++) begin
      @(negedge __clk);
      if (i + 1 == hold) begin
        rw_ = 1'b1;
        rr_ = 1'b1;
      end
      if (!(dok_ && den_ && dpe_) || ddt_ !== 16'hFFFF) bad++;
    end
    rw_ = 1'b1;
    rr_ = 1'b1;
    tests++;
    if (bad != 0 || seen != s) begin
      fails++;
      $display("FAIL %s: got %0d active cycles, %0d responses, want 0 and 0", name, bad, seen - s);
    end
    idle(4);
  endtask

  initial begin
    int s;
    int k;
    repeat (3) @(negedge __clk);
    tests++;
    if ({dok_, den_, dpe_, ddt_} !== {3'b111, 16'hFFFF}) begin
      fails++;
      $display("FAIL reset_state: got %b%b%b ddt=%h, want 111 ddt=ffff", dok_, den_, dpe_, ddt_);
    end
    __rst = 1'b0;
    idle(3);

    xfer(1'b1, 16'h0110, 16'h1234, W_OK);
    xfer(1'b0, 16'h0110, 16'h0000, r_ok(16'h1234));
    xfer(1'b1, 16'h0100, 16'hBEEF, W_OK);
    xfer(1'b0, 16'h0100, 16'h0000, r_ok(16'hBEEF));
    xfer(1'b1, 16'h0050, 16'h5555, W_EN);
    xfer(1'b1, 16'h00FF, 16'h5555, W_EN);

    xfer(1'b1, 16'h0130, 16'h0F0F, W_OK);
    silent("nb_mismatch", 1'b1, 1'b0, 4'd3, 16'h0130, 16'hDEAD, 500, 500);
    silent("addr_range", 1'b1, 1'b0, 4'd0, 16'h8130, 16'hDEAD, 500, 500);
    xfer(1'b0, 16'h0130, 16'h0000, r_ok(16'h0F0F));

    @(negedge __clk) par_inj = 1'b1;
    @(negedge __clk) par_inj = 1'b0;
    xfer(1'b1, 16'h0120, 16'hAAAA, W_OK);
    xfer(1'b0, 16'h0120, 16'h0000, r_pe(16'hAAAA));
    xfer(1'b1, 16'h0120, 16'hAAAA, W_OK);
    xfer(1'b0, 16'h0120, 16'h0000, r_ok(16'hAAAA));

    silent("abort_in_wait", 1'b1, 1'b0, 4'd0, 16'h0110, 16'hFFFF, 3, 30);
    xfer(1'b0, 16'h0110, 16'h0000, r_ok(16'h1234));
    silent("both_strobes", 1'b1, 1'b1, 4'd0, 16'h0110, 16'h0000, 50, 50);
    xfer(1'b0, 16'h0110, 16'h0000, r_ok(16'h1234));

    // Master clear while responding: release timed by the monitor.
    start(1'b0, 16'h0100, 16'h0000, r_ok(16'hBEEF));
    @(negedge __clk);
    rel_t0 = cyc;
    rel_chk = 1'b1;
    rmcl_ = 1'b0;
    k = 0;
    while (rel_chk && k < 20) begin
      @(posedge __clk);
      k++;
    end
    tests++;
    if (rel_chk) begin
      fails++;
      $display("FAIL rmcl_release: outputs still active after 20 cycles, want released");
      rel_chk = 1'b0;
    end
    @(negedge __clk);
    rr_ = 1'b1;
    rmcl_ = 1'b1;
    idle(4);
    xfer(1'b0, 16'h0100, 16'h0000, r_ok(16'hBEEF));

    // Asynchronous reset in the middle of a response.
    start(1'b0, 16'h0110, 16'h0000, r_ok(16'h1234));
    @(posedge __clk);
    #2 __rst = 1'b1;
    #1;
    tests++;
    if ({dok_, den_, dpe_, ddt_} !== {3'b111, 16'hFFFF}) begin
      fails++;
      $display("FAIL async_reset: got %b%b%b ddt=%h, want 111 ddt=ffff", dok_, den_, dpe_, ddt_);
    end
    rr_ = 1'b1;
    idle(2);
    __rst = 1'b0;
    s = seen;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge __clk);
      if (!(dok_ && den_ && dpe_)) k++;
    end
    tests++;
    if (k != 0 || seen != s) begin
      fails++;
      $display("FAIL post_reset_glitch: got %0d active cycles, want 0", k);
    end
    xfer(1'b0, 16'h0110, 16'h0000, r_ok(16'h1234));

    tests++;
    if (q.size() != 0 || unexpected != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, %0d unexpected, want 0 and 0",
               q.size(), unexpected);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule
